// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the frame writer: default raster size, Wishbone
//   registered-feedback cycle type identifiers, the bus-side FSM state type and
//   a small width helper used to size counters.
// -----------------------------------------------------------------------------
package vga_pkg;

    // Default raster geometry (active area only).
    localparam int HDISP_DEFAULT = 800;
    localparam int VDISP_DEFAULT = 480;

    // Wishbone cycle type identifiers carried on wshb_cti.
    localparam logic [2:0] CTI_CLASSIC = 3'b000;  // no burst in progress
    localparam logic [2:0] CTI_INCR    = 3'b010;  // incrementing burst, more beats follow
    localparam logic [2:0] CTI_END     = 3'b111;  // final beat of the burst

    // Bus-side state: waiting for a full burst's worth of data, or bursting.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } fw_state_e;

    // Counter width for a modulus n; never narrower than one bit so that a
    // degenerate n of 1 still yields a legal vector.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_writer_if.sv
// -----------------------------------------------------------------------------
// frame_writer_if
//   Wishbone B4 write-only master bundle used by frame_writer to push pixels
//   into frame memory.
//
//   wshb_adr     32  byte address of the current beat
//   wshb_dat_ms  32  write data, master to slave
//   wshb_sel      4  byte lane enables
//   wshb_cyc      1  bus cycle in progress
//   wshb_stb      1  beat strobe
//   wshb_we       1  write enable
//   wshb_cti      3  cycle type identifier
//   wshb_bte      2  burst type extension
//   wshb_ack      1  slave acknowledge, slave to master
// -----------------------------------------------------------------------------
interface frame_writer_if;

    logic [31:0] wshb_adr;
    logic [31:0] wshb_dat_ms;
    logic [3:0]  wshb_sel;
    logic        wshb_cyc;
    logic        wshb_stb;
    logic        wshb_we;
    logic [2:0]  wshb_cti;
    logic [1:0]  wshb_bte;
    logic        wshb_ack;

    modport master (
        output wshb_adr,
        output wshb_dat_ms,
        output wshb_sel,
        output wshb_cyc,
        output wshb_stb,
        output wshb_we,
        output wshb_cti,
        output wshb_bte,
        input  wshb_ack
    );

    modport slave (
        input  wshb_adr,
        input  wshb_dat_ms,
        input  wshb_sel,
        input  wshb_cyc,
        input  wshb_stb,
        input  wshb_we,
        input  wshb_cti,
        input  wshb_bte,
        output wshb_ack
    );

endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO. The head entry is always
//   presented on rd_data; rd_en consumes it. Writes while full and reads while
//   empty are ignored. A simultaneous read and write leaves the count unchanged
//   and both complete.
//
//   clk      in   1           clock
//   rst_n    in   1           asynchronous active-low reset (empties FIFO)
//   wr_en    in   1           push wr_data (ignored when full)
//   wr_data  in   DATA_WIDTH  data to push
//   rd_en    in   1           pop head entry (ignored when empty)
//   rd_data  out  DATA_WIDTH  head entry
//   full     out  1           no free entry
//   count    out  CW          number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int  DATA_WIDTH = 24,
    parameter int  DEPTH      = 32,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign full    = (count == CW'(DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && (count != '0);
    assign rd_data = mem[rd_ptr];

    // Pointer advance with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // NOTE: the storage array has no reset; its contents are only ever read
    // behind the count, so clearing it would add reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_rd) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frame_writer.sv
// -----------------------------------------------------------------------------
// frame_writer
//   Accepts a stream of 24-bit RGB pixels and writes them to frame memory as
//   fixed-length incrementing Wishbone write bursts, one 32-bit word per pixel
//   ({8'h00, rgb}). Pixel 0 of the frame (marked by pix_sof) lands at BASE_ADR;
//   addresses advance by 4 per beat and return to BASE_ADR after the last
//   word of the frame.
//
//   Input side: pixels are buffered in a 2*BURST_LEN deep FIFO. Until the
//   first pix_sof after reset, accepted pixels are dropped so that memory is
//   always written frame-aligned. A pix_sof arriving anywhere but pixel 0 is
//   flagged on sof_err and otherwise treated as an ordinary pixel (no resync).
//
//   Bus side: a burst starts only once BURST_LEN words are buffered, so the
//   FIFO can never run dry mid-burst and stb is never withdrawn.
//
//   clk          in   1   clock (also the Wishbone clock)
//   rst_n        in   1   asynchronous active-low reset
//   pix_valid    in   1   pixel present on pix_data
//   pix_ready    out  1   pixel accepted this cycle if pix_valid
//   pix_data     in   24  RGB pixel
//   pix_sof      in   1   pix_data is pixel 0 of a frame
//   frame_done   out  1   one-cycle pulse after the last beat of a frame
//   sof_err      out  1   one-cycle pulse after a misplaced pix_sof
//   wshb         master   Wishbone write port (see frame_writer_if)
// -----------------------------------------------------------------------------
module frame_writer
    import vga_pkg::*;
#(
    parameter int          HDISP     = HDISP_DEFAULT,
    parameter int          VDISP     = VDISP_DEFAULT,
    parameter int          BURST_LEN = 16,
    parameter logic [31:0] BASE_ADR  = 32'h0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pix_valid,
    output logic           pix_ready,
    input  logic [23:0]    pix_data,
    input  logic           pix_sof,
    output logic           frame_done,
    output logic           sof_err,
    frame_writer_if.master wshb
);

    localparam int NPIX  = HDISP * VDISP;
    localparam int PW    = clog2_min1(NPIX);
    localparam int DEPTH = 2 * BURST_LEN;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int BW    = clog2_min1(BURST_LEN);

    // -------------------------------------------------------------------------
    // Input side
    // -------------------------------------------------------------------------
    logic          sof_seen;
    logic [PW-1:0] pcnt;
    logic          fifo_wr;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [23:0]   fifo_head;
    logic          beat_done;

    assign pix_ready = !fifo_full;

    // Pixels are handshaken even before the first sof (so the source is never
    // stalled), but only stored once the frame alignment is known.
    assign fifo_wr = pix_valid && pix_ready && (sof_seen || pix_sof);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sof_seen <= 1'b0;
            pcnt     <= '0;
            sof_err  <= 1'b0;
        end else begin
            sof_err <= fifo_wr && pix_sof && (pcnt != '0);
            if (fifo_wr) begin
                sof_seen <= 1'b1;
                pcnt     <= (pcnt == PW'(NPIX - 1)) ? '0 : pcnt + PW'(1);
            end
        end
    end

    sync_fifo #(
        .DATA_WIDTH (24),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (pix_data),
        .rd_en   (beat_done),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    // -------------------------------------------------------------------------
    // Bus side
    // -------------------------------------------------------------------------
    fw_state_e     state_q;
    fw_state_e     state_d;
    logic [BW-1:0] bcnt;
    logic [PW-1:0] wcnt;
    logic [31:0]   adr_q;
    logic          last_beat;
    logic          frame_last;
    logic          bus_act;
    logic [2:0]    cti;

    assign last_beat  = (bcnt == BW'(BURST_LEN - 1));
    assign frame_last = (wcnt == PW'(NPIX - 1));
    assign beat_done  = (state_q == BURST) && wshb.wshb_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Control strobes decode straight from the state flop, so an asynchronous
    // reset drops cyc in the same cycle it is asserted.
    // NOTE: every signal driven here gets a default before the case so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        bus_act = 1'b0;
        cti     = CTI_CLASSIC;
        case (state_q)
            IDLE: begin
                if (fifo_count >= CW'(BURST_LEN)) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                bus_act = 1'b1;
                cti     = last_beat ? CTI_END : CTI_INCR;
                if (wshb.wshb_ack && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat-within-burst, word-within-frame and address all advance on ack;
    // the address is registered so it never depends combinationally on ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt       <= '0;
            wcnt       <= '0;
            adr_q      <= BASE_ADR;
            frame_done <= 1'b0;
        end else begin
            frame_done <= beat_done && frame_last;
            if (beat_done) begin
                bcnt  <= last_beat ? '0 : bcnt + BW'(1);
                wcnt  <= frame_last ? '0 : wcnt + PW'(1);
                adr_q <= frame_last ? BASE_ADR : adr_q + 32'd4;
            end
        end
    end

    assign wshb.wshb_cyc    = bus_act;
    assign wshb.wshb_stb    = bus_act;
    assign wshb.wshb_we     = bus_act;
    assign wshb.wshb_cti    = cti;
    assign wshb.wshb_adr    = adr_q;
    assign wshb.wshb_dat_ms = {8'h00, fifo_head};
    assign wshb.wshb_sel    = 4'b1111;
    assign wshb.wshb_bte    = 2'b00;

endmodule

// File: tb/tb_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_frame_writer
//   Self-checking bench for frame_writer (8x4 raster, 4-beat bursts). A
//   behavioural model keeps the queue of stored-but-unwritten pixels and the
//   frame word index; each cycle the bus outputs are compared against what
//   that queue implies. Directed literal checks pin the model itself.
// -----------------------------------------------------------------------------
module tb_frame_writer;

    localparam int          HD    = 8;
    localparam int          VD    = 4;
    localparam int          BL    = 4;
    localparam int          NPIX  = HD * VD;
    localparam int          DEPTH = 2 * BL;
    localparam logic [31:0] BASE  = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [23:0] pix_data = '0;
    logic        pix_sof = 1'b0;
    logic        frame_done;
    logic        sof_err;

    frame_writer_if bus ();

    frame_writer #(
        .HDISP     (HD),
        .VDISP     (VD),
        .BURST_LEN (BL),
        .BASE_ADR  (BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .frame_done (frame_done),
        .sof_err    (sof_err),
        .wshb       (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model (updated on the falling edge, ahead of the rising
    // edge at which the sampled handshakes take effect)
    // ---------------------------------------------------------------------
    logic [23:0] exp_q[$];
    bit          sof_seen_m = 0;
    int          pcnt_m     = 0;
    int          wcnt_m     = 0;
    bit          exp_fd     = 0;
    bit          exp_se     = 0;
    bit          prev_cyc   = 0;
    bit          prev_ack   = 0;
    int          prev_size  = 0;
    int          m_size;

    int          burst_cnt    = 0;
    int          fd_cnt       = 0;
    int          se_cnt       = 0;
    bit          got_first    = 0;
    logic [31:0] first_adr    = 32'hFFFF_FFFF;
    logic [31:0] first_dat    = 32'hFFFF_FFFF;
    logic [31:0] last_ack_adr = 32'hFFFF_FFFF;

    always @(negedge clk) begin
        if (!rst_n) begin
            check1("rst_cyc", bus.wshb_cyc, 1'b0);
            check1("rst_stb", bus.wshb_stb, 1'b0);
            check1("rst_we", bus.wshb_we, 1'b0);
            check("rst_cti", 32'(bus.wshb_cti), 32'd0);
            check("rst_adr", bus.wshb_adr, BASE);
            check1("rst_frame_done", frame_done, 1'b0);
            check1("rst_sof_err", sof_err, 1'b0);
            check1("rst_pix_ready", pix_ready, 1'b1);
            exp_q.delete();
            sof_seen_m = 0;
            pcnt_m     = 0;
            wcnt_m     = 0;
            exp_fd     = 0;
            exp_se     = 0;
            prev_cyc   = 0;
            prev_ack   = 0;
            prev_size  = 0;
            got_first  = 0;
        end else begin
            m_size = exp_q.size();
            check1("pix_ready", pix_ready, m_size < DEPTH);
            check("adr", bus.wshb_adr, BASE + 32'(4 * wcnt_m));
            check1("frame_done", frame_done, exp_fd);
            check1("sof_err", sof_err, exp_se);
            check("sel", 32'(bus.wshb_sel), 32'hF);
            check("bte", 32'(bus.wshb_bte), 32'h0);
            if (frame_done) fd_cnt++;
            if (sof_err) se_cnt++;

            if (prev_cyc && prev_ack && (wcnt_m % BL == 0))
                check1("burst_end", bus.wshb_cyc, 1'b0);

            if (bus.wshb_cyc) begin
                check1("stb", bus.wshb_stb, 1'b1);
                check1("we", bus.wshb_we, 1'b1);
                if (!prev_cyc) begin
                    burst_cnt++;
                    check("burst_start_align", 32'(wcnt_m % BL), 32'd0);
                    check1("burst_start_level", prev_size >= BL, 1'b1);
                end
                if (m_size == 0) begin
                    check1("beat_without_data", bus.wshb_cyc, 1'b0);
                end else begin
                    check("dat_ms", bus.wshb_dat_ms, {8'h00, exp_q[0]});
                    check("cti", 32'(bus.wshb_cti), (wcnt_m % BL == BL - 1) ? 32'h7 : 32'h2);
                end
                if (!got_first) begin
                    got_first = 1;
                    first_adr = bus.wshb_adr;
                    first_dat = bus.wshb_dat_ms;
                end
            end else begin
                check("cti_idle", 32'(bus.wshb_cti), 32'h0);
                check1("stb_idle", bus.wshb_stb, 1'b0);
                check1("we_idle", bus.wshb_we, 1'b0);
                if (prev_cyc && !prev_ack)
                    check1("stall_abort", bus.wshb_cyc, 1'b1);
                if (!prev_cyc && prev_size >= BL)
                    check1("burst_launch", bus.wshb_cyc, 1'b1);
            end

            // Effects of the coming rising edge.
            exp_fd = bus.wshb_cyc && bus.wshb_ack && (wcnt_m == NPIX - 1);
            if (bus.wshb_cyc && bus.wshb_ack && m_size > 0) begin
                last_ack_adr = bus.wshb_adr;
                void'(exp_q.pop_front());
                wcnt_m = (wcnt_m + 1) % NPIX;
            end
            exp_se = 0;
            if (pix_valid && pix_ready && (sof_seen_m || pix_sof)) begin
                if (pix_sof && pcnt_m != 0) exp_se = 1;
                sof_seen_m = 1;
                exp_q.push_back(pix_data);
                pcnt_m = (pcnt_m + 1) % NPIX;
            end
            prev_cyc  = bus.wshb_cyc;
            prev_ack  = bus.wshb_ack;
            prev_size = m_size;
        end
    end

    // ---------------------------------------------------------------------
    // Slave acknowledge: 0 always high, 1 random, 2 held low, 3 one-in-four
    // ---------------------------------------------------------------------
    int ack_mode = 0;
    int ack_tick = 0;

    initial begin
        bus.wshb_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ack_tick++;
            case (ack_mode)
                0:       bus.wshb_ack = 1'b1;
                1:       bus.wshb_ack = 1'($urandom_range(0, 1));
                2:       bus.wshb_ack = 1'b0;
                default: bus.wshb_ack = (ack_tick % 4 == 3);
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (entered and left just after a rising edge)
    // ---------------------------------------------------------------------
    task automatic send_pix(input logic [23:0] d, input logic s);
        bit ok = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = s;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (pix_ready) ok = 1;
            else if (k == 399) check1("ready_timeout", pix_ready, 1'b1);
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !bus.wshb_cyc) done = 1;
        end
        if (!done) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int fd0, se0, b0, acc;
    bit hit;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pixels ahead of the first sof are dropped; then one full frame.
        ack_mode = 0;
        for (int i = 0; i < 5; i++) send_pix(24'hAA0000 + 24'(i), 1'b0);
        fd0 = fd_cnt; se0 = se_cnt; b0 = burst_cnt;
        for (int i = 0; i < NPIX; i++) send_pix(24'h100000 + 24'(i), i == 0);
        wait_drain();
        check("p1_first_adr", first_adr, BASE);
        check("p1_first_dat", first_dat, 32'h0010_0000);
        check("p1_bursts", 32'(burst_cnt - b0), 32'd8);
        check("p1_frame_done", 32'(fd_cnt - fd0), 32'd1);
        check("p1_last_adr", last_ack_adr, BASE + 32'd124);
        check("p1_sof_err", 32'(se_cnt - se0), 32'd0);

        // Three-cycle ack stalls on every beat.
        ack_mode = 3;
        fd0 = fd_cnt;
        for (int i = 0; i < NPIX; i++) send_pix(24'h200000 + 24'(i), i == 0);
        wait_drain();
        check("p2a_frame_done", 32'(fd_cnt - fd0), 32'd1);

        // Random data, random ack, random input gaps; sof on frame boundaries.
        ack_mode = 1;
        fd0 = fd_cnt; se0 = se_cnt;
        for (int i = 0; i < 2 * NPIX; i++) begin
            send_pix(24'($urandom), (i % NPIX) == 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain();
        check("p2b_frame_done", 32'(fd_cnt - fd0), 32'd2);
        check("p2b_sof_err", 32'(se_cnt - se0), 32'd0);

        // Ack held low under continuous input: FIFO fills to its depth.
        ack_mode = 2;
        acc = 0;
        pix_valid = 1'b1;
        pix_sof   = 1'b0;
        pix_data  = 24'h300000;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (pix_ready) acc++;
            @(posedge clk);
            #1;
            pix_data = 24'h300000 + 24'(acc);
        end
        pix_valid = 1'b0;
        check("p3_accepted", 32'(acc), 32'd8);
        @(negedge clk);
        check1("p3_ready_low", pix_ready, 1'b0);
        @(posedge clk);
        #1;
        ack_mode = 1;
        wait_drain();

        // Misplaced sof at pixel 10 of a fresh frame.
        pulse_reset();
        fd0 = fd_cnt; se0 = se_cnt;
        for (int i = 0; i < 3; i++) send_pix(24'hBB0000 + 24'(i), 1'b0);
        for (int i = 0; i < NPIX; i++) send_pix(24'h400000 + 24'(i), (i == 0) || (i == 10));
        wait_drain();
        check("p4_sof_err", 32'(se_cnt - se0), 32'd1);
        check("p4_frame_done", 32'(fd_cnt - fd0), 32'd1);
        check("p4_first_adr", first_adr, BASE);
        check("p4_first_dat", first_dat, 32'h0040_0000);

        // Reset asserted during beat 2 of a burst.
        ack_mode = 0;
        for (int i = 0; i < BL; i++) send_pix(24'h500000 + 24'(i), i == 0);
        hit = 0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            if (bus.wshb_cyc && bus.wshb_adr == BASE + 32'd4) hit = 1;
        end
        check1("p5_beat2_seen", hit, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check1("p5_cyc_drop", bus.wshb_cyc, 1'b0);
        check1("p5_stb_drop", bus.wshb_stb, 1'b0);
        check1("p5_we_drop", bus.wshb_we, 1'b0);
        check("p5_cti", 32'(bus.wshb_cti), 32'h0);
        check("p5_adr", bus.wshb_adr, BASE);
        check1("p5_frame_done", frame_done, 1'b0);
        check1("p5_pix_ready", pix_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fd0 = fd_cnt;
        for (int i = 0; i < 2; i++) send_pix(24'hCC0000 + 24'(i), 1'b0);
        for (int i = 0; i < NPIX; i++) send_pix(24'h600000 + 24'(i), i == 0);
        wait_drain();
        check("p5_first_adr", first_adr, BASE);
        check("p5_first_dat", first_dat, 32'h0060_0000);
        check("p5_frame_done_after", 32'(fd_cnt - fd0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: bench did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
